memory_controller: RTL and testbench
====================================

MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 Parameter WAIT_STATES, default 2: number of stall cycles inserted before each memory access; legal range 0-15.
REQ-002 Parameter DEPTH, default 256: number of 16-bit data words in the internal RAM, mapped at addresses 0x0000 to DEPTH-1.
REQ-003 Port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port address, input, 16 bits: word address from the processor address bus.
REQ-006 Port data_in, input, 16 bits: write data from the processor data bus.
REQ-007 Port MW, input, 1 bit: memory-write request, level-sampled.
REQ-008 Port MR, input, 1 bit: memory-read request, level-sampled.
REQ-009 Port data_out, output, 16 bits: registered read data.
REQ-010 Port ready, output, 1 bit: one-cycle completion pulse.
REQ-011 Port busy, output, 1 bit: high while a transaction is in progress.
REQ-012 Port error, output, 1 bit: one-cycle pulse flagging an illegal request.
REQ-013 Port io_out, output, 16 bits: memory-mapped output register at address 0xFFFF.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT and DONE.
REQ-015 IDLE with exactly one of MW/MR high: latch address, data_in and direction; load the wait counter with WAIT_STATES; set busy=1; go to WAIT.
REQ-016 WAIT with counter not zero: decrement the counter and stay in WAIT.
REQ-017 WAIT with counter zero: perform the access on this edge; set ready=1; go to DONE.
REQ-018 DONE: clear ready and busy; go to IDLE unconditionally.
REQ-019 Latency: a request sampled at edge E0 SHALL raise ready at edge E0+WAIT_STATES+1, for exactly one cycle.
REQ-020 MW/MR SHALL be ignored in WAIT and DONE.
- No queuing of requests.
- The processor must hold or re-issue the request after ready.
REQ-021 MW and MR both high in IDLE:
- error=1 for one cycle.
- No state change, no memory access, no ready.
REQ-022 Write to an address below DEPTH: RAM[address] <= latched data_in on the access edge.
REQ-023 Read from an address below DEPTH: data_out <= RAM[address] on the access edge.
REQ-024 Address 0xFFFF:
- Write updates io_out.
- Read returns io_out on data_out.
REQ-025 Any other address (DEPTH to 0xFFFE):
- A write is discarded.
- A read returns 0x0000.
- error=1 in the same cycle as ready.
- ready still pulses.
REQ-026 data_out SHALL hold its last value, except when a read completes.
REQ-027 Addresses SHALL NOT wrap: the full 16-bit address is compared, not truncated to log2(DEPTH) bits.
REQ-028 Internal RAM contents are not initialised and SHALL NOT be altered by reset.

Reset
REQ-029 While reset=0, the block SHALL be held in reset:
- State is IDLE; wait counter is 0.
- ready=0, busy=0, error=0.
- data_out=0x0000, io_out=0x0000.
REQ-030 Reset asserted mid-transaction:
- Abort immediately.
- A write not yet at its access edge SHALL NOT be committed.
REQ-031 The first request SHALL be sampled on the first rising edge after reset returns to 1.

Verification
REQ-032 WAIT_STATES=2: write 0x1234 to 0x0010, then read 0x0010. Required:
- ready rises 3 edges after each sample.
- busy is high for 4 cycles.
- data_out=0x1234.
REQ-033 WAIT_STATES=0: back-to-back reads of written addresses 0x0000 and 0x00FF. Required:
- ready on the edge after each sample.
- A request held through DONE is re-sampled in the next IDLE.
REQ-034 Write 0xBEEF to 0xFFFF. Required:
- io_out=0xBEEF after ready.
- A read of 0xFFFF returns 0xBEEF.
REQ-035 Read 0x0100 with DEPTH=256. Required:
- data_out=0x0000; error and ready pulse together.
- A write of 0x5555 to 0x0100 leaves RAM[0x0000] unchanged.
REQ-036 MW=MR=1 in IDLE. Required:
- error pulses one cycle.
- busy stays 0; no ready.
REQ-037 Write 0xAAAA to 0x0020, with reset asserted during WAIT. Required:
- All outputs return to reset values.
- After releasing reset, a read of 0x0020 does not return 0xAAAA, given prior contents 0x0000.

Source files
------------

// File: rtl/memory_controller.sv
// Wait-state memory controller: one request at a time through IDLE/WAIT/DONE,
// backed by an internal word RAM plus a memory-mapped output register at 0xFFFF.
module memory_controller #(
  parameter int WAIT_STATES = 2,
  parameter int DEPTH       = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [15:0] data_in,
  input  logic        MW,
  input  logic        MR,
  output logic [15:0] data_out,
  output logic        ready,
  output logic        busy,
  output logic        error,
  output logic [15:0] io_out
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);
  localparam logic [3:0]  WS_L    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        error_q, error_d;
  logic [15:0] data_out_q, data_out_d;
  logic [15:0] io_q, io_d;

  logic [15:0]   ram [DEPTH];
  logic [AW-1:0] ram_idx;
  logic [15:0]   ram_rdata;
  logic          ram_we;
  logic          is_io;
  logic          in_ram;

  assign ram_idx   = addr_q[AW-1:0];
  assign ram_rdata = ram[ram_idx];
  // Full 17-bit compare so out-of-range addresses never alias into the RAM.
  assign is_io     = (addr_q == 16'hFFFF);
  assign in_ram    = ({1'b0, addr_q} < DEPTH_L);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    ready_d    = 1'b0;
    busy_d     = busy_q;
    error_d    = 1'b0;
    data_out_d = data_out_q;
    io_d       = io_q;
    ram_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (MW ^ MR) begin
          addr_d  = address;
          wdata_d = data_in;
          write_d = MW;
          cnt_d   = WS_L;
          busy_d  = 1'b1;
          state_d = WAIT;
        end else if (MW && MR) begin
          error_d = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready_d = 1'b1;
          state_d = DONE;
          if (is_io) begin
            if (write_q) io_d = wdata_q;
            else         data_out_d = io_q;
          end else if (in_ram) begin
            if (write_q) ram_we = 1'b1;
            else         data_out_d = ram_rdata;
          end else begin
            error_d = 1'b1;
            if (!write_q) data_out_d = 16'h0000;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      write_q    <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
      data_out_q <= 16'h0000;
      io_q       <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
      data_out_q <= data_out_d;
      io_q       <= io_d;
    end
  end

  // RAM is deliberately outside the reset domain; reset gating stops a write
  // from landing on an edge that coincides with reset being held.
  always_ff @(posedge clock) begin
    if (ram_we && reset) ram[ram_idx] <= wdata_q;
  end

  assign data_out = data_out_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign error    = error_q;
  assign io_out   = io_q;

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: table of transactions on a WAIT_STATES=2
// instance, plus hand sequences for illegal requests, mid-transaction reset and WAIT_STATES=0.
module tb_memory_controller;

  localparam int WS = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] addr = 16'h0, din = 16'h0;
  logic        mw = 1'b0, mr = 1'b0;
  logic [15:0] data_out, io_out;
  logic        ready, busy, error;

  logic [15:0] addr1 = 16'h0, din1 = 16'h0;
  logic        mw1 = 1'b0, mr1 = 1'b0;
  logic [15:0] data_out1, io_out1;
  logic        ready1, busy1, error1;

  int total = 0;
  int passed = 0;

  always #5 clock = ~clock;

  memory_controller #(.WAIT_STATES(WS), .DEPTH(256)) dut (
    .clock(clock), .reset(reset), .address(addr), .data_in(din), .MW(mw), .MR(mr),
    .data_out(data_out), .ready(ready), .busy(busy), .error(error), .io_out(io_out)
  );

  memory_controller #(.WAIT_STATES(0), .DEPTH(256)) dut0ws (
    .clock(clock), .reset(reset), .address(addr1), .data_in(din1), .MW(mw1), .MR(mr1),
    .data_out(data_out1), .ready(ready1), .busy(busy1), .error(error1), .io_out(io_out1)
  );

  typedef struct {
    logic        w;
    logic        r;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] dout;
    logic        err;
    logic [15:0] io;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // One complete transaction on the WAIT_STATES=2 instance; request dropped after E0.
  task automatic txn(input string nm, input logic w, input logic r, input logic [15:0] a,
                     input logic [15:0] d, input logic [15:0] exp_dout, input logic exp_err,
                     input logic [15:0] exp_io);
    int rdy_at, busy_n, err_n;
    logic [15:0] dout_at;
    rdy_at = 0; busy_n = 0; err_n = 0; dout_at = 16'h0;
    @(negedge clock);
    mw = w; mr = r; addr = a; din = d;
    @(posedge clock); #1;
    mw = 1'b0; mr = 1'b0;
    if (busy) busy_n++;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      if (ready && rdy_at == 0) begin
        rdy_at = k;
        dout_at = data_out;
      end
      if (error) err_n++;
      if (busy) busy_n++;
      else break;
    end
    chk($sformatf("%s ready_latency", nm), 16'(rdy_at), 16'(WS + 1));
    chk($sformatf("%s busy_cycles", nm), 16'(busy_n), 16'(WS + 2));
    chk($sformatf("%s error_pulses", nm), 16'(err_n), {15'd0, exp_err});
    chk($sformatf("%s data_out", nm), dout_at, exp_dout);
    chk($sformatf("%s io_out", nm), io_out, exp_io);
  endtask

  // Single transaction on the WAIT_STATES=0 instance: ready expected on E0+1.
  task automatic txn0(input string nm, input logic w, input logic r, input logic [15:0] a,
                      input logic [15:0] d, input logic [15:0] exp_dout);
    @(negedge clock);
    mw1 = w; mr1 = r; addr1 = a; din1 = d;
    @(posedge clock); #1;
    mw1 = 1'b0; mr1 = 1'b0;
    chk($sformatf("%s busy", nm), {15'd0, busy1}, 16'd1);
    chk($sformatf("%s no_early_ready", nm), {15'd0, ready1}, 16'd0);
    @(posedge clock); #1;
    chk($sformatf("%s ready", nm), {15'd0, ready1}, 16'd1);
    chk($sformatf("%s data_out", nm), data_out1, exp_dout);
    @(posedge clock); #1;
    chk($sformatf("%s busy_clear", nm), {15'd0, busy1}, 16'd0);
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b0, 16'h0010, 16'h1234, 16'h0000, 1'b0, 16'h0000};
    vt[1]  = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'h1234, 1'b0, 16'h0000};
    vt[2]  = '{1'b1, 1'b0, 16'hFFFF, 16'hBEEF, 16'h1234, 1'b0, 16'hBEEF};
    vt[3]  = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'hBEEF, 1'b0, 16'hBEEF};
    vt[4]  = '{1'b1, 1'b0, 16'h0000, 16'h0F0F, 16'hBEEF, 1'b0, 16'hBEEF};
    vt[5]  = '{1'b0, 1'b1, 16'h0100, 16'h0000, 16'h0000, 1'b1, 16'hBEEF};
    vt[6]  = '{1'b1, 1'b0, 16'h0100, 16'h5555, 16'h0000, 1'b1, 16'hBEEF};
    vt[7]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0F0F, 1'b0, 16'hBEEF};
    vt[8]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0F0F, 1'b0, 16'hBEEF};
    vt[9]  = '{1'b1, 1'b0, 16'h00FF, 16'hCAFE, 16'h0F0F, 1'b0, 16'hBEEF};
    vt[10] = '{1'b0, 1'b1, 16'h00FF, 16'h0000, 16'hCAFE, 1'b0, 16'hBEEF};
    vt[11] = '{1'b0, 1'b1, 16'h8000, 16'h0000, 16'h0000, 1'b1, 16'hBEEF};
    vt[12] = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'h1234, 1'b0, 16'hBEEF};
    vt[13] = '{1'b1, 1'b0, 16'hFFFE, 16'h7777, 16'h1234, 1'b1, 16'hBEEF};
    vt[14] = '{1'b0, 1'b1, 16'hFFFE, 16'h0000, 16'h0000, 1'b1, 16'hBEEF};
    vt[15] = '{1'b0, 1'b1, 16'h00FF, 16'h0000, 16'hCAFE, 1'b0, 16'hBEEF};

    // Reset values while held
    repeat (3) @(negedge clock);
    chk("rst ready", {15'd0, ready}, 16'd0);
    chk("rst busy", {15'd0, busy}, 16'd0);
    chk("rst error", {15'd0, error}, 16'd0);
    chk("rst data_out", data_out, 16'h0000);
    chk("rst io_out", io_out, 16'h0000);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      txn($sformatf("vec%0d", i), vt[i].w, vt[i].r, vt[i].a, vt[i].d,
          vt[i].dout, vt[i].err, vt[i].io);
    end

    // MW and MR together in IDLE
    @(negedge clock);
    mw = 1'b1; mr = 1'b1; addr = 16'h0010; din = 16'h9999;
    @(posedge clock); #1;
    mw = 1'b0; mr = 1'b0;
    chk("both error", {15'd0, error}, 16'd1);
    chk("both busy", {15'd0, busy}, 16'd0);
    chk("both ready", {15'd0, ready}, 16'd0);
    @(posedge clock); #1;
    chk("both error_clear", {15'd0, error}, 16'd0);
    chk("both busy_after", {15'd0, busy}, 16'd0);
    chk("both ready_after", {15'd0, ready}, 16'd0);
    txn("after_both read", 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h1234, 1'b0, 16'hBEEF);
    txn("pre_rst read", 1'b0, 1'b1, 16'h00FF, 16'h0000, 16'hCAFE, 1'b0, 16'hBEEF);

    // Reset asserted during WAIT of a write
    @(negedge clock);
    mw = 1'b1; addr = 16'h0020; din = 16'hAAAA;
    @(posedge clock); #1;
    mw = 1'b0;
    @(posedge clock); #1;
    chk("mid busy_before_rst", {15'd0, busy}, 16'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst ready", {15'd0, ready}, 16'd0);
    chk("mid_rst busy", {15'd0, busy}, 16'd0);
    chk("mid_rst error", {15'd0, error}, 16'd0);
    chk("mid_rst data_out", data_out, 16'h0000);
    chk("mid_rst io_out", io_out, 16'h0000);
    repeat (3) @(posedge clock);
    #1;
    chk("held_rst busy", {15'd0, busy}, 16'd0);
    reset = 1'b1;
    txn("post_rst read20", 1'b0, 1'b1, 16'h0020, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    txn("post_rst read10", 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h1234, 1'b0, 16'h0000);

    // WAIT_STATES=0 instance
    txn0("ws0 wr0000", 1'b1, 1'b0, 16'h0000, 16'h1111, 16'h0000);
    txn0("ws0 wr00FF", 1'b1, 1'b0, 16'h00FF, 16'h2222, 16'h0000);
    txn0("ws0 rd0000", 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h1111);
    txn0("ws0 rd00FF", 1'b0, 1'b1, 16'h00FF, 16'h0000, 16'h2222);

    // Held read request is re-sampled in the IDLE that follows DONE
    @(negedge clock);
    mr1 = 1'b1; addr1 = 16'h0000;
    @(posedge clock); #1;
    addr1 = 16'h00FF;
    @(posedge clock); #1;
    chk("ws0 held ready1", {15'd0, ready1}, 16'd1);
    chk("ws0 held dout1", data_out1, 16'h1111);
    @(posedge clock); #1;
    chk("ws0 held done_busy", {15'd0, busy1}, 16'd0);
    chk("ws0 held done_ready", {15'd0, ready1}, 16'd0);
    @(posedge clock); #1;
    mr1 = 1'b0;
    chk("ws0 held resample_busy", {15'd0, busy1}, 16'd1);
    @(posedge clock); #1;
    chk("ws0 held ready2", {15'd0, ready1}, 16'd1);
    chk("ws0 held dout2", data_out1, 16'h2222);
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("ws0 held idle_after", {15'd0, busy1}, 16'd0);
    chk("ws0 error_never", {15'd0, error1}, 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
